// File: rtl/decode_stage.sv
// decode_stage: RV32I integer-ALU decode stage with a 32x32 register file,
// write-through bypass, a busy scoreboard for RAW hazards and a one-entry
// registered output with valid/ready handshake.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   in_valid/in_ready, instr    instruction input handshake
//   wb_en, wb_rd, wb_data       register writeback port
//   out_valid/out_ready         output handshake toward execute
//   alu_control, op_a, op_b     ALU opcode and operands
//   rd, rd_we, illegal          destination, write enable, unsupported flag
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_control,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        illegal
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } dec_t;

  logic [31:0][31:0] rf_q;
  logic [31:0]       busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  dec_t              out_q, out_d, dec;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_val, rs2_val;
  logic        hazard, accept;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Read ports with write-through bypass from the writeback port.
  always_comb begin
    rs1_val = rf_q[rs1];
    rs2_val = rf_q[rs2];
    if (wb_en && wb_rd == rs1) rs1_val = wb_data;
    if (wb_en && wb_rd == rs2) rs2_val = wb_data;
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  always_comb begin
    dec     = '0;
    dec.alu = 4'd2;
    dec.ill = 1'b1;
    case (opcode)
      OPC_R: begin
        dec.a   = rs1_val;
        dec.b   = rs2_val;
        dec.ill = 1'b0;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec.alu = 4'd2;
            3'b001:  dec.alu = 4'd3;
            3'b100:  dec.alu = 4'd7;
            3'b101:  dec.alu = 4'd5;
            3'b110:  dec.alu = 4'd1;
            3'b111:  dec.alu = 4'd0;
            default: dec.ill = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec.alu = 4'd4;
        end else begin
          dec.ill = 1'b1;
        end
        // Register shifts only use the low five bits of the amount.
        if (funct3 == 3'b001 || funct3 == 3'b101) dec.b = {27'b0, rs2_val[4:0]};
      end
      OPC_I: begin
        dec.a   = rs1_val;
        dec.b   = {{20{instr[31]}}, instr[31:20]};
        dec.ill = 1'b0;
        case (funct3)
          3'b000:  dec.alu = 4'd2;
          3'b100:  dec.alu = 4'd7;
          3'b110:  dec.alu = 4'd1;
          3'b111:  dec.alu = 4'd0;
          3'b001, 3'b101: begin
            // SRAI and other funct7 values are not supported.
            dec.alu = (funct3 == 3'b001) ? 4'd3 : 4'd5;
            dec.b   = {27'b0, instr[24:20]};
            if (funct7 != 7'b0000000) dec.ill = 1'b1;
          end
          default: dec.ill = 1'b1;
        endcase
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec     = '0;
      dec.alu = 4'd2;
      dec.ill = 1'b1;
    end else begin
      dec.rd = instr[11:7];
      dec.we = (instr[11:7] != 5'd0);
    end
  end

  // A source that is being written back this cycle is satisfied by the bypass.
  always_comb begin
    hazard = 1'b0;
    if (rs1 != 5'd0 && busy_q[rs1] && !(wb_en && wb_rd == rs1)) hazard = 1'b1;
    if (opcode == OPC_R && rs2 != 5'd0 && busy_q[rs2] && !(wb_en && wb_rd == rs2))
      hazard = 1'b1;
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Clear first so a same-register set on acceptance wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_rd] = 1'b0;
    if (accept && dec.we) busy_d[dec.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q        <= '0;
      busy_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wb_en && wb_rd != 5'd0) rf_q[wb_rd] <= wb_data;
      busy_q      <= busy_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_control = out_q.alu;
  assign op_a        = out_q.a;
  assign op_b        = out_q.b;
  assign rd          = out_q.rd;
  assign rd_we       = out_q.we;
  assign illegal     = out_q.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage: the driver issues stimulus and
// pushes expected decode results from a behavioural model; a monitor pops and
// compares whenever the DUT presents an output.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [3:0]  alu_control;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd;
  logic        rd_we, illegal;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
    .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  // ALU code per funct3 (-1 = not a plain-table entry).
  localparam int RTAB [8] = '{2, 3, -1, -1, 7, 5, 1, 0};
  localparam int ITAB [8] = '{2, -1, -1, -1, 7, -1, 1, 0};

  int checks = 0;
  int fails  = 0;

  exp_t        q[$];
  logic [31:0] regs_m [32];
  bit          busy_m [32];
  bit          ov_m;

  function automatic exp_t ref_dec(logic [31:0] i, logic [31:0] v1, logic [31:0] v2);
    exp_t e;
    int   c;
    logic [2:0] f3;
    f3 = i[14:12];
    e = '0;
    c = -1;
    e.a = v1;
    if (i[6:0] == 7'h33) begin
      if (i[31:25] == 7'h00) c = RTAB[f3];
      else if (i[31:25] == 7'h20 && f3 == 3'd0) c = 4;
      e.b = (c == 3 || c == 5) ? (v2 % 32) : v2;
    end else if (i[6:0] == 7'h13) begin
      c = ITAB[f3];
      if (c >= 0) e.b = 32'($signed(i[31:20]));
      else if ((f3 == 3'd1 || f3 == 3'd5) && i[31:25] == 7'h00) begin
        c = (f3 == 3'd1) ? 3 : 5;
        e.b = 32'(i[24:20]);
      end
    end
    if (c < 0) begin
      e = '0;
      e.alu = 4'd2;
      e.ill = 1'b1;
    end else begin
      e.alu = c[3:0];
      e.rd  = i[11:7];
      e.we  = (i[11:7] != 5'd0);
    end
    return e;
  endfunction

  function automatic logic [31:0] r_enc(logic [6:0] f7, logic [4:0] s2, logic [4:0] s1,
                                        logic [2:0] f3, logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] i_enc(logic [11:0] imm, logic [4:0] s1, logic [2:0] f3,
                                        logic [4:0] d);
    return {imm, s1, f3, d, 7'h13};
  endfunction

  // Register value as seen by decode this cycle (writeback forwarded).
  function automatic logic [31:0] rv(logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_rd == r) return wb_data;
    return regs_m[r];
  endfunction

  function automatic bit src_blocked(logic [4:0] r);
    return r != 5'd0 && busy_m[r] && !(wb_en && wb_rd == r);
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 32; k++) begin
      regs_m[k] = '0;
      busy_m[k] = 1'b0;
    end
    ov_m = 1'b0;
    q.delete();
  endtask

  task automatic chk_zero(string tag);
    checks++;
    if ({out_valid, alu_control, op_a, op_b, rd, rd_we, illegal} !== '0) begin
      fails++;
      $display("FAIL %s: outputs during reset v=%b alu=%0d a=%h b=%h rd=%0d we=%b ill=%b, required all 0",
               tag, out_valid, alu_control, op_a, op_b, rd, rd_we, illegal);
    end
  endtask

  // One clock of stimulus; entered and left at posedge+2.
  task automatic cycle(logic [31:0] i, logic v, logic we, logic [4:0] wr,
                       logic [31:0] wd, logic ordy);
    bit   hz, mr;
    exp_t e;
    instr = i; in_valid = v; wb_en = we; wb_rd = wr; wb_data = wd; out_ready = ordy;
    hz = src_blocked(i[19:15]) || (i[6:0] == 7'h33 && src_blocked(i[24:20]));
    mr = (!ov_m || ordy) && !hz;
    e  = ref_dec(i, rv(i[19:15]), rv(i[24:20]));
    @(negedge clk);
    checks++;
    if (in_ready !== mr) begin
      fails++;
      $display("FAIL in_ready: instr=%h got %b required %b", i, in_ready, mr);
    end
    @(posedge clk);
    if (v && mr) q.push_back(e);
    ov_m = (v && mr) ? 1'b1 : (ordy ? 1'b0 : ov_m);
    if (we) busy_m[wr] = 1'b0;
    if (v && mr && e.we) busy_m[e.rd] = 1'b1;
    if (we && wr != 5'd0) regs_m[wr] = wd;
    #2;
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    chk_zero(tag);
    in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b0; instr = '0;
    clear_model();
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;
  endtask

  // Monitor: output presence must match the scoreboard, contents must match its head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (out_valid !== (q.size() != 0)) begin
          fails++;
          $display("FAIL out_valid: got %b required %b", out_valid, q.size() != 0);
        end else if (out_valid) begin
          if (alu_control !== q[0].alu || op_a !== q[0].a || op_b !== q[0].b ||
              rd_we !== q[0].we || illegal !== q[0].ill || (!q[0].ill && rd !== q[0].rd)) begin
            fails++;
            $display("FAIL issue: got alu=%0d a=%h b=%h rd=%0d we=%b ill=%b required alu=%0d a=%h b=%h rd=%0d we=%b ill=%b",
                     alu_control, op_a, op_b, rd, rd_we, illegal,
                     q[0].alu, q[0].a, q[0].b, q[0].rd, q[0].we, q[0].ill);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] ri;
    logic [4:0]  d, s1, s2;
    logic [2:0]  f3;
    rst = 1'b1; in_valid = 1'b0; instr = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b0;
    clear_model();
    #3;
    chk_zero("reset_initial");
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;

    // x1=5, x2=3, then ADD x3,x1,x2
    cycle(32'h0, 1'b0, 1'b1, 5'd1, 32'd5, 1'b1);
    cycle(32'h0, 1'b0, 1'b1, 5'd2, 32'd3, 1'b1);
    cycle(r_enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    // ADDI x4,x0,-1 ; SRLI x5,x1,31
    cycle(i_enc(12'hFFF, 5'd0, 3'd0, 5'd4), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(i_enc(12'd31, 5'd1, 3'd5, 5'd5), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    // make x1 busy, stall ADD x6,x1,x2, then release via writeback x1=9
    cycle(i_enc(12'd7, 5'd0, 3'd0, 5'd1), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(r_enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd6), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(r_enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd6), 1'b1, 1'b1, 5'd1, 32'd9, 1'b1);
    // downstream stall for 3 cycles, then release
    for (int k = 0; k < 3; k++)
      cycle(i_enc(12'd1, 5'd0, 3'd0, 5'd7), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(i_enc(12'd1, 5'd0, 3'd0, 5'd7), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    // all-zero word is illegal; then R-type shift with large rs2 value
    cycle(32'h0, 1'b1, 1'b1, 5'd2, 32'hFFFF_FFE3, 1'b1);
    cycle(r_enc(7'h00, 5'd2, 5'd0, 3'd1, 5'd8), 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
    // reset while stalled with a held instruction
    cycle(i_enc(12'd2, 5'd0, 3'd0, 5'd9), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(i_enc(12'd2, 5'd0, 3'd0, 5'd9), 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    do_reset("reset_mid_stall");

    for (int n = 0; n < 600; n++) begin
      d  = 5'($urandom_range(0, 7));
      s1 = 5'($urandom_range(0, 7));
      s2 = 5'($urandom_range(0, 7));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0, 1, 2: ri = r_enc(($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, s2, s1, f3, d);
        3:       ri = r_enc(7'($urandom), s2, s1, f3, d);
        4, 5:    ri = i_enc(12'($urandom), s1, f3, d);
        6:       ri = i_enc({($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, 5'($urandom)},
                            s1, ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5, d);
        7:       ri = $urandom;
        8:       ri = 32'h0;
        default: ri = {7'($urandom), s2, s1, f3, d, 7'h13};
      endcase
      cycle(ri, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 7);
      if (n == 300) do_reset("reset_random");
    end

    for (int k = 0; k < 4; k++) cycle(32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected issues never presented, required 0", q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 clk  input  1  rising-edge clock; the only clock in the block.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid  input  1  instr is valid this cycle.
REQ-004 in_ready  output  1  stage accepts instr this cycle.
REQ-005 instr  input  32  RV32I instruction word.
REQ-006 wb_en  input  1  writeback strobe.
REQ-007 wb_rd  input  5  writeback destination register.
REQ-008 wb_data  input  32  writeback value.
REQ-009 out_valid  output  1  registered ALU-side outputs are valid.
REQ-010 out_ready  input  1  downstream execute stage consumes outputs.
REQ-011 alu_control  output  4  ALU opcode: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SUB, 5 SRL, 7 XOR.
REQ-012 op_a  output  32  ALU first operand (rs1 value).
REQ-013 op_b  output  32  ALU second operand (rs2 value or immediate).
REQ-014 rd  output  5  destination register of the issued instruction.
REQ-015 rd_we  output  1  issued instruction writes rd.
REQ-016 illegal  output  1  issued instruction is not supported.

Function
REQ-017 The block SHALL contain a 32x32 register file; reads of x0 return 0; writes to x0 are ignored.
REQ-018 When wb_en=1, the block SHALL write wb_data to register wb_rd on the rising edge.
REQ-019 If a decode read address equals wb_rd with wb_en=1 (wb_rd!=0), the read SHALL return wb_data in the same cycle (write-through bypass).
REQ-020 Opcode 0110011 SHALL decode as: funct3 000/funct7 0000000 -> 2; 000/0100000 -> 4; 001/0000000 -> 3; 100/0000000 -> 7; 101/0000000 -> 5; 110/0000000 -> 1; 111/0000000 -> 0; op_a=rs1, op_b=rs2.
REQ-021 For R-type SLL/SRL, op_b SHALL be {27'b0, rs2[4:0]}.
REQ-022 Opcode 0010011 SHALL decode as: ADDI 000 -> 2; XORI 100 -> 7; ORI 110 -> 1; ANDI 111 -> 0; op_b = instr[31:20] sign-extended to 32 bits.
REQ-023 SLLI (001, instr[31:25]=0) -> 3; SRLI (101, instr[31:25]=0) -> 5; op_b = {27'b0, instr[24:20]}.
REQ-024 Any other encoding SHALL issue with illegal=1, rd_we=0, alu_control=2, op_a=op_b=0.
REQ-025 For legal instructions, rd_we SHALL be 1 iff instr[11:7]!=0; rd = instr[11:7].
REQ-026 A scoreboard busy[31:1] SHALL be set for rd when a legal instruction with rd_we=1 is accepted.
REQ-027 busy[wb_rd] SHALL clear on a writeback with wb_en=1; if set and clear coincide on the same register, set wins.
REQ-028 hazard SHALL be 1 when a used source (rs1 always; rs2 for R-type only; x0 never) is busy and not being written back this cycle.
REQ-029 in_ready SHALL equal (!out_valid || out_ready) && !hazard; it depends on instr, not on in_valid.
REQ-030 On in_valid && in_ready, the decoded outputs SHALL be registered and out_valid SHALL be 1 the next cycle (latency 1).
REQ-031 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-032 On out_ready with no new acceptance, out_valid SHALL drop to 0 the next cycle; back-to-back issue SHALL sustain 1 instruction per cycle.
REQ-033 Illegal instructions SHALL not modify the scoreboard.

Reset
REQ-034 While rst=1, out_valid, alu_control, op_a, op_b, rd, rd_we, illegal, all busy bits and all registers SHALL be 0, independent of clk.
REQ-035 Reset asserted mid-stall SHALL discard the held instruction; in_ready SHALL be 1 in the first cycle after release.

Verification
REQ-036 After reset, with wb x1=5 and x2=3, issuing ADD x3,x1,x2 -> next cycle out_valid=1, alu_control=2, op_a=5, op_b=3, rd=3, rd_we=1.
REQ-037 ADDI x4,x0,-1 -> op_a=0, op_b=32'hFFFFFFFF, alu_control=2; SRLI x5,x1,31 -> op_b=31, alu_control=5.
REQ-038 With x1 busy, issue ADD x6,x1,x2 -> in_ready=0; a writeback of x1=9 in that cycle -> in_ready=1 and op_a=9 next cycle.
REQ-039 Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; raise out_ready -> next instruction issues the following cycle.
REQ-040 instr=32'h00000000 -> illegal=1, rd_we=0, scoreboard unchanged; assert rst mid-operation -> all outputs 0 asynchronously.
